// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths, reset level and state encoding for pipe_stage_reg.
// Optional skid entry is enabled by defining PIPE_SKID_EN.
package pipe_stage_reg_pkg;

  localparam logic RstEnable = 1'b1;

  localparam int unsigned AluOpBusW   = 8;
  localparam int unsigned AluFunBusW  = 3;
  localparam int unsigned RegBusW     = 32;
  localparam int unsigned RegAddrBusW = 5;

  // aluop + alufun + reg1 + reg2 + wd + wreg
  localparam int unsigned IdExPayloadW =
    AluOpBusW + AluFunBusW + 2 * RegBusW
    + RegAddrBusW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry for pipe_stage_reg: one payload slot plus its valid bit.
// Ports: clk_i/rst_i, flush_i, push_i/pop_i, data_i -> valid_o/data_o.
module pipe_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline register with flush and saturating stall count.
// Ports: clk, rst (sync high), flush, in_valid/in_ready/in_data,
//   out_valid/out_ready/out_data, stall_cnt. Skid entry: PIPE_SKID_EN.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = IdExPayloadW,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  pipe_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept;
  logic                 consume;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic                 skid_push;
  logic                 skid_pop;
  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_data;

  pipe_skid_buf #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  (in_data),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  // Straight from the skid valid flop: no path from out_ready.
  assign in_ready = !skid_valid;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_push = 1'b0;
    skid_pop  = 1'b0;
`endif
    if (flush) begin
      // Same-cycle accept is dropped with the rest.
      state_d = ST_EMPTY;
      main_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
`ifdef PIPE_SKID_EN
            state_d   = ST_SKID;
            skid_push = 1'b1;
`endif
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        ST_SKID: begin
          // Oldest entry always drains first.
          if (consume) begin
            state_d  = ST_FULL;
            main_d   = skid_data;
            skid_pop = 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && !flush
        && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (either PIPE_SKID_EN setting).
// Uses CNT_W=4 so counter saturation is reachable.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int unsigned PW = 81;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .PAYLOAD_W (PW),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b1;
    in_data = 81'h1_2345_6789;
    out_ready = 1'b0;

    // Reset held two cycles with a live input.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, '0);
      check("rst_cnt", stall_cnt, '0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Streaming 0x01..0x10, no bubbles.
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data = PW'(i);
      tick();
      check("strm_valid", out_valid, 1'b1);
      check("strm_data", out_data, 128'(i));
      check("strm_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check("strm_drain", out_valid, 1'b0);
    check("strm_cnt", stall_cnt, 4'd0);

    // Back-pressure.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 81'hA0;
    tick();
    check("bp_a_valid", out_valid, 1'b1);
    check("bp_a_data", out_data, 81'hA0);
    in_data = 81'hB0;
`ifdef PIPE_SKID_EN
    #1;
    check("bp_rdy_b", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_rdy_lo", in_ready, 1'b0);
    check("bp_hold_a", out_data, 81'hA0);
    check("bp_cnt1", stall_cnt, 4'd1);
    tick();
    check("bp_hold_a2", out_data, 81'hA0);
    check("bp_cnt2", stall_cnt, 4'd2);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_reg", in_ready, 1'b0);
    tick();
    check("bp_b_data", out_data, 81'hB0);
    check("bp_b_valid", out_valid, 1'b1);
    check("bp_rdy_back", in_ready, 1'b1);
    tick();
    check("bp_empty", out_valid, 1'b0);
    check("bp_cnt_fin", stall_cnt, 4'd2);
`else
    #1;
    check("bp_rdy_lo", in_ready, 1'b0);
    tick();
    check("bp_hold_a", out_data, 81'hA0);
    check("bp_cnt1", stall_cnt, 4'd1);
    check("bp_rdy_lo2", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_comb", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_b_data", out_data, 81'hB0);
    check("bp_b_valid", out_valid, 1'b1);
    tick();
    check("bp_empty", out_valid, 1'b0);
    check("bp_cnt_fin", stall_cnt, 4'd1);
`endif

    // Flush with held entries and a same-cycle offer.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 81'hA0;
    tick();
`ifdef PIPE_SKID_EN
    in_data = 81'hB0;
    tick();
    check("fl_skid_full", in_ready, 1'b0);
`endif
    flush = 1'b1;
    out_ready = 1'b1;
    in_data = 81'hC0;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", out_valid, 1'b0);
    check("fl_data", out_data, '0);
    check("fl_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_stay_empty", out_valid, 1'b0);
      check("fl_stay_zero", out_data, '0);
    end

    // Counter saturation, then reset together with flush.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 81'h55;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("sat_cnt5", stall_cnt, 4'd5);
    for (int i = 0; i < 15; i++) tick();
    check("sat_cnt15", stall_cnt, 4'd15);
    check("sat_hold", out_data, 81'h55);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    check("rf_cnt", stall_cnt, 4'd0);
    check("rf_valid", out_valid, 1'b0);
    check("rf_data", out_data, '0);
    check("rf_ready", in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
